// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline handshake fabric: default geometry,
// classic five-stage indices and the packed-bus slice helper.
package pipe_pkg;

  localparam int DEF_STAGES = 5;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 32;

  typedef enum int {
    STAGE_IF  = 0,
    STAGE_ID  = 1,
    STAGE_EX  = 2,
    STAGE_MEM = 3,
    STAGE_WB  = 4
  } stage_e;

  // Low bit of slice idx inside a packed bus of width-wide slices.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Handshake/payload bundle between the pipeline fabric (slave) and the
// surrounding CPU stage logic (master).
interface pipe_stage_chain_if
  import pipe_pkg::*;
#(
  parameter int STAGES = DEF_STAGES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) ();

  logic                      in_valid;
  logic [DATA_W-1:0]         in_data;
  logic                      in_allowin;
  logic [STAGES-1:0]         ready_go;
  logic [STAGES-1:0]         flush_vec;
  logic [STAGES*DATA_W-1:0]  stage_data_in;
  logic [STAGES-1:0]         stage_valid;
  logic [STAGES*DATA_W-1:0]  stage_data;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_allowin;
  logic [STAGES*CNT_W-1:0]   stall_cnt;

  modport slave (
    input  in_valid, in_data, ready_go, flush_vec, stage_data_in, out_allowin,
    output in_allowin, stage_valid, stage_data, out_valid, out_data, stall_cnt
  );

  modport master (
    output in_valid, in_data, ready_go, flush_vec, stage_data_in, out_allowin,
    input  in_allowin, stage_valid, stage_data, out_valid, out_data, stall_cnt
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// One pipeline slot: valid bit, payload register, flush override and, when
// PIPE_STALL_CNT_EN is defined, a saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              allowin,
  input  logic              up_valid,
  input  logic [DATA_W-1:0] up_data,
  input  logic              flush,
  input  logic              stall,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  cnt
);

  // NOTE: state registers use non-blocking assignments so every slot samples
  // its upstream neighbour's pre-edge value, independent of evaluation order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      valid <= 1'b0;
    else if (flush)   valid <= 1'b0;
    else if (allowin) valid <= up_valid;
  end

  // NOTE: payload is reset as well so forwarding taps never expose X after
  // reset; beyond that it only loads on a real transfer and holds on bubbles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                  data <= '0;
    else if (allowin && up_valid) data <= up_data;
  end

`ifdef PIPE_STALL_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                  cnt <= '0;
    else if (stall && cnt != '1)  cnt <= cnt + CNT_ONE;
  end
`else
  logic unused_stall;
  assign unused_stall = stall;
  assign cnt          = '0;
`endif

endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised valid/allowin pipeline fabric with per-stage ready_go, flush
// and forwarding taps. Optional stall counters: define PIPE_STALL_CNT_EN.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int STAGES = DEF_STAGES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               resetn,
  pipe_stage_chain_if.slave  bus
);

  logic [1:0]        rst_sync;
  logic              rst_n_int;
  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] go;
  logic [STAGES-1:0] allowin;
  logic [STAGES-1:0] down_allowin;
  logic [STAGES-1:0] stall;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  assign go = valid & bus.ready_go;

  // Backpressure walks from the sink towards stage 0 within one cycle.
  // in_valid is deliberately absent here, so in_allowin never depends on it.
  // NOTE: every always_comb output gets a value before the loop, so no latch
  // can be inferred whatever the loop bounds.
  always_comb begin
    logic acc;
    allowin      = '0;
    down_allowin = '0;
    acc          = bus.out_allowin;
    for (int i = STAGES - 1; i >= 0; i--) begin
      down_allowin[i] = acc;
      acc             = !valid[i] | (go[i] & acc);
      allowin[i]      = acc;
    end
  end

  assign stall = valid & ~(bus.ready_go & down_allowin);

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic              up_valid;
    logic [DATA_W-1:0] up_data;

    if (i == 0) begin : g_head
      assign up_valid = bus.in_valid;
      assign up_data  = bus.in_data;
    end else begin : g_body
      assign up_valid = go[i-1];
      assign up_data  = bus.stage_data_in[slice_lo(i - 1, DATA_W) +: DATA_W];
    end

    pipe_stage_reg #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_reg (
      .clk      (clk),
      .resetn   (rst_n_int),
      .allowin  (allowin[i]),
      .up_valid (up_valid),
      .up_data  (up_data),
      .flush    (bus.flush_vec[i]),
      .stall    (stall[i]),
      .valid    (valid[i]),
      .data     (bus.stage_data[slice_lo(i, DATA_W) +: DATA_W]),
      .cnt      (bus.stall_cnt[slice_lo(i, CNT_W) +: CNT_W])
    );
  end

  assign bus.in_allowin  = allowin[0];
  assign bus.out_valid   = go[STAGES-1];
  assign bus.out_data    = bus.stage_data_in[slice_lo(STAGES - 1, DATA_W) +: DATA_W];
  assign bus.stage_valid = valid;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: directed table and corner
// sequences plus randomized traffic against a slot-level reference model.
module tb_pipe_stage_chain;
  import pipe_pkg::*;

  localparam int STAGES = DEF_STAGES;
  localparam int DATA_W = DEF_DATA_W;
`ifdef PIPE_STALL_CNT_EN
  localparam int CNT_W  = 4;
`else
  localparam int CNT_W  = DEF_CNT_W;
`endif
  localparam logic [STAGES-1:0] ALL1 = '1;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  pipe_stage_chain_if #(.STAGES(STAGES), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  pipe_stage_chain #(.STAGES(STAGES), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Directed tests let the external stages pass payloads through unchanged;
  // the random test rewrites every slice with fresh data.
  logic                     use_rand;
  logic [STAGES*DATA_W-1:0] rand_sdi;
  assign bus.stage_data_in = use_rand ? rand_sdi : bus.stage_data;

  int n_checks = 0;
  int n_err    = 0;
  logic [DATA_W-1:0] got[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [DATA_W-1:0] id,
                       input logic [STAGES-1:0] rg, input logic [STAGES-1:0] fl,
                       input logic oa);
    bus.in_valid    = iv;
    bus.in_data     = id;
    bus.ready_go    = rg;
    bus.flush_vec   = fl;
    bus.out_allowin = oa;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_collect();
    #1;
    if (bus.out_valid && bus.out_allowin) got.push_back(bus.out_data);
    tick();
  endtask

  task automatic do_reset();
    use_rand = 1'b0;
    rand_sdi = '0;
    drive(1'b0, '0, ALL1, '0, 1'b1);
    resetn = 1'b0;
    #13;
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic fill_stalled(input logic [DATA_W-1:0] base);
    drive(1'b0, '0, ALL1, '0, 1'b0);
    for (int k = 0; k < STAGES; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = base + DATA_W'(k);
      tick_collect();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_got(input string name, input logic [DATA_W-1:0] base, input int n);
    check({name, "_count"}, 256'(got.size()), 256'(n));
    for (int k = 0; k < n && k < got.size(); k++)
      check({name, "_item"}, 256'(got[k]), 256'(base + DATA_W'(k)));
  endtask

  typedef struct {
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              exp_ov;
    logic [DATA_W-1:0] exp_od;
  } vec_t;

  vec_t tbl[14];

  // Reference model: per-slot occupancy and contents.
  logic              m_valid[STAGES];
  logic [DATA_W-1:0] m_data[STAGES];
  int unsigned       m_cnt[STAGES];

  task automatic run_random(input int cycles);
    logic              allow[STAGES+1];
    logic              nv[STAGES];
    logic [DATA_W-1:0] nd[STAGES];
    logic              iv, oa, up_v;
    logic [DATA_W-1:0] id, up_d;
    logic [STAGES-1:0] rg, fl, exp_sv;
    logic [STAGES*DATA_W-1:0] exp_sd;
    logic [STAGES*CNT_W-1:0]  exp_sc;
    int unsigned cnt_max;
    cnt_max = (CNT_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CNT_W) - 1);
    for (int i = 0; i < STAGES; i++) begin
      m_valid[i] = 1'b0; m_data[i] = '0; m_cnt[i] = 0;
    end
    use_rand = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      iv = 1'($urandom_range(0, 1));
      id = DATA_W'($urandom());
      oa = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < STAGES; i++) rg[i] = ($urandom_range(0, 4) != 0);
      fl = '0;
      if ($urandom_range(0, 19) == 0) fl = STAGES'((1 << $urandom_range(1, STAGES)) - 1);
      for (int i = 0; i < STAGES; i++) rand_sdi[i*DATA_W +: DATA_W] = DATA_W'($urandom());
      drive(iv, id, rg, fl, oa);

      allow[STAGES] = oa;
      for (int i = STAGES - 1; i >= 0; i--)
        allow[i] = !m_valid[i] || (rg[i] && allow[i+1]);
      for (int i = 0; i < STAGES; i++) begin
        exp_sv[i] = m_valid[i];
        exp_sd[i*DATA_W +: DATA_W] = m_data[i];
        exp_sc[i*CNT_W +: CNT_W]   = CNT_W'(m_cnt[i]);
      end
      #1;
      check("rnd_in_allowin", 256'(bus.in_allowin), 256'(allow[0]));
      check("rnd_out_valid", 256'(bus.out_valid), 256'(m_valid[STAGES-1] && rg[STAGES-1]));
      check("rnd_out_data", 256'(bus.out_data), 256'(rand_sdi[(STAGES-1)*DATA_W +: DATA_W]));
      check("rnd_stage_valid", 256'(bus.stage_valid), 256'(exp_sv));
      check("rnd_stage_data", 256'(bus.stage_data), 256'(exp_sd));
      check("rnd_stall_cnt", 256'(bus.stall_cnt), 256'(exp_sc));

      for (int i = 0; i < STAGES; i++) begin
        up_v  = (i == 0) ? iv : (m_valid[i-1] && rg[i-1]);
        up_d  = (i == 0) ? id : rand_sdi[(i-1)*DATA_W +: DATA_W];
        nv[i] = fl[i] ? 1'b0 : (allow[i] ? up_v : m_valid[i]);
        nd[i] = (allow[i] && up_v) ? up_d : m_data[i];
`ifdef PIPE_STALL_CNT_EN
        if (m_valid[i] && !(rg[i] && allow[i+1]) && m_cnt[i] < cnt_max) m_cnt[i]++;
`endif
      end
      for (int i = 0; i < STAGES; i++) begin
        m_valid[i] = nv[i];
        m_data[i]  = nd[i];
      end
      tick();
    end
    use_rand = 1'b0;
  endtask

  initial begin
    do_reset();

    // Full flow: 0x11..0x18 back to back, first output 5 cycles after first offer.
    for (int k = 0; k < 14; k++) begin
      tbl[k].in_valid = (k < 8);
      tbl[k].in_data  = (k < 8) ? DATA_W'(32'h11 + k) : '0;
      tbl[k].exp_ov   = (k >= 5) && (k < 13);
      tbl[k].exp_od   = (k >= 5) ? DATA_W'(32'h11 + k - 5) : '0;
    end
    for (int k = 0; k < 14; k++) begin
      drive(tbl[k].in_valid, tbl[k].in_data, ALL1, '0, 1'b1);
      #1;
      check("flow_in_allowin", 256'(bus.in_allowin), 256'(1'b1));
      check("flow_out_valid", 256'(bus.out_valid), 256'(tbl[k].exp_ov));
      if (tbl[k].exp_ov) check("flow_out_data", 256'(bus.out_data), 256'(tbl[k].exp_od));
      tick();
    end

    // Asynchronous reset in the middle of traffic.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, DATA_W'(32'h60 + k), ALL1, '0, 1'b1);
      tick();
    end
    drive(1'b0, '0, ALL1, '0, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_stage_valid", 256'(bus.stage_valid), 256'(0));
    check("rst_stage_data", 256'(bus.stage_data), 256'(0));
    check("rst_in_allowin", 256'(bus.in_allowin), 256'(1'b1));
    do_reset();

    // Back-pressure: full pipe held by the sink, then drained.
    fill_stalled(DATA_W'(32'hA0));
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_in_allowin", 256'(bus.in_allowin), 256'(1'b0));
      check("bp_stage_valid", 256'(bus.stage_valid), 256'(ALL1));
      check("bp_stage_data", 256'(bus.stage_data),
            256'({32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4}));
      tick();
    end
    got.delete();
    bus.out_allowin = 1'b1;
    for (int k = 0; k < 8; k++) tick_collect();
    check_got("bp_drain", DATA_W'(32'hA0), 5);

    // Mid-pipe stall on stage EX.
    do_reset();
    fill_stalled(DATA_W'(32'hD0));
    got.delete();
    drive(1'b0, '0, ALL1 & ~(STAGES'(1) << STAGE_EX), '0, 1'b1);
    #1;
    check("mid_in_allowin", 256'(bus.in_allowin), 256'(1'b0));
    tick_collect();
    tick_collect();
    #1;
    check("mid_stage_valid", 256'(bus.stage_valid), 256'(5'b00111));
    check("mid_stage_data_low", 256'(bus.stage_data[3*DATA_W-1:0]),
          256'({32'hD2, 32'hD3, 32'hD4}));
    bus.ready_go = ALL1;
    for (int k = 0; k < 6; k++) tick_collect();
    check_got("mid_drain", DATA_W'(32'hD0), 5);

    // Flush of IF/ID while the branch sits in EX.
    do_reset();
    got.delete();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, DATA_W'(32'hB0 + k), ALL1, '0, 1'b1);
      tick_collect();
    end
    drive(1'b1, DATA_W'(32'hB3), ALL1, 5'b00011, 1'b1);
    tick_collect();
    drive(1'b0, '0, ALL1, '0, 1'b1);
    #1;
    check("flush_stage_valid", 256'(bus.stage_valid), 256'(5'b01100));
    check("flush_branch_data", 256'(bus.stage_data[3*DATA_W +: DATA_W]), 256'(32'hB0));
    for (int k = 0; k < 6; k++) tick_collect();
    check_got("flush_drain", DATA_W'(32'hB0), 2);

`ifdef PIPE_STALL_CNT_EN
    // Saturating stall counter on the last stage.
    do_reset();
    drive(1'b1, DATA_W'(32'h77), ALL1, '0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    repeat (24) tick();
    check("cnt_sat", 256'(bus.stall_cnt[4*CNT_W +: CNT_W]), 256'(4'hF));
    repeat (3) tick();
    check("cnt_stick", 256'(bus.stall_cnt[4*CNT_W +: CNT_W]), 256'(4'hF));
    check("cnt_if_idle", 256'(bus.stall_cnt[0 +: CNT_W]), 256'(0));
`endif

    // Randomized traffic against the reference model.
    do_reset();
    run_random(600);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised replacement for the hand-wired IF/ID/EX/MEM/WB handshake (valid/allowin) fabric in the CPU top.
- Provides STAGES registered pipeline slots, each DATA_W wide, with per-stage ready_go, per-stage flush, and combinational forwarding taps.
- Stage logic (decode, ALU, memory) sits outside and feeds ready_go and bus payload; this block owns only valid bits, payload registers and the backpressure chain.

Parameters:
- STAGES, 5, number of pipeline slots (≥2).
- DATA_W, 32, payload width per stage (≥1).
- CNT_W, 32, stall-counter width (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer has a payload for stage 0.
- in_data  in  DATA_W  payload for stage 0.
- in_allowin  out  1  stage 0 can accept this cycle.
- ready_go  in  STAGES  bit i: stage i work done, may advance.
- flush_vec  in  STAGES  bit i: kill stage i content at the next edge.
- stage_data_in  in  STAGES*DATA_W  slice i: payload to pass from stage i to stage i+1 (external stage may rewrite it); slice STAGES-1 drives out_data.
- stage_valid  out  STAGES  registered valid of each slot (forwarding tap).
- stage_data  out  STAGES*DATA_W  registered payload of each slot (forwarding tap).
- out_valid  out  1  last stage valid && ready_go.
- out_data  out  DATA_W  slice STAGES-1 of stage_data_in.
- out_allowin  in  1  sink accepts.
- stall_cnt  out  STAGES*CNT_W  per-stage stall counts (optional feature).

Behaviour:
- Definitions: go[i] = valid[i] & ready_go[i]; allowin[STAGES] = out_allowin; allowin[i] = !valid[i] | (go[i] & allowin[i+1]).
- Handshake legs: in_allowin = allowin[0]; out_valid = go[STAGES-1].
- All handshake signals are combinational in the same cycle. No combinational path exists from in_valid to in_allowin.
- Reset: all valid bits = 0, all payload registers = 0, stall counters = 0. Asynchronous assertion, synchronous release. Any in-flight content is lost.
- Valid update at each edge:
  - Stage 0: if allowin[0], valid[0] <= in_valid.
  - Stage i>0: if allowin[i], valid[i] <= go[i-1].
  - Otherwise valid holds.
- Payload update: payload[i] loads only when allowin[i] and the upstream valid is 1. Stage 0 loads in_data; stage i loads slice i-1 of stage_data_in. Otherwise payload holds (no bubble zeroing).
- Flush: flush_vec[i] forces valid[i] <= 0 at the next edge, overriding any load.
  - A stage that is flushing still presents go[i]/allowin[i] normally in that cycle, so its content may move downstream unless that downstream stage is also flushed.
  - The caller must flush all younger stages together.
- Simultaneous load into stage i and flush_vec[i]: flush wins; the payload may update but valid = 0.
- Latency: minimum 1 cycle per stage. A payload accepted at edge n reaches out_valid in the cycle after edge n+STAGES-1 when all ready_go = 1 and out_allowin = 1.
- Throughput: 1 item/cycle with no bubbles under full flow.
- Stall propagates fully in the same cycle: out_allowin = 0 with all stages valid drives every allowin to 0.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- Defined: per-stage saturating counter increments each cycle in which valid[i] & !(ready_go[i] & allowin[i+1]). Counters stick at all-ones and clear only on reset.
- Undefined: counters are not built; stall_cnt is tied to 0. The port list is unchanged.

Decomposition:
- Package pipe_pkg: default STAGES/DATA_W, stage index constants (IF=0, ID=1, EX=2, MEM=3, WB=4), and the slice helper function for packed buses.
- Sub-module pipe_stage_reg: one slot (valid, payload, flush, optional counter). The chain instantiates it in a generate loop and computes the allowin chain.

Test Plan (STAGES=5, DATA_W=32 unless stated):
- Reset: drive resetn=0 mid-stream → stage_valid=5'b0, stage_data=0, in_allowin=1 immediately, without waiting for a clock edge.
- Full flow: all ready_go=1, out_allowin=1, feed 0x11..0x18 on consecutive cycles → out_valid high 4 edges after first accept, out_data 0x11..0x18 consecutive with no gaps.
- Back-pressure: fill all 5 stages, then out_allowin=0 for 3 cycles → in_allowin=0 and all payloads held. Release → 5 items drain in order with no duplication or loss.
- Mid-stall: ready_go[2]=0 for 2 cycles with stages 0..2 full → stages 3..4 drain, stages 0..1 hold, in_allowin=0. Re-assert → order preserved.
- Flush: stage 2 holds 0xB0 (branch), flush_vec=5'b00011 for one cycle → 0xB0 advances, stages 0..1 invalid next cycle, and the item arriving at stage 0 is dropped.
- Stall counter (PIPE_STALL_CNT_EN, CNT_W=4): hold stage 4 valid with out_allowin=0 for 20 cycles → stall_cnt slice 4 = 4'hF and stays there.
